// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and small helpers for the character-LCD controller.
package lcd_pkg;

  // HD44780 command bytes
  localparam logic [7:0] LCD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_HOME      = 8'h02;
  localparam logic [7:0] LCD_ENTRY_INC = 8'h06;
  localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
  localparam logic [7:0] LCD_FUNC_8B2L = 8'h38;
  localparam logic [7:0] LCD_SET_DDRAM = 8'h80;

  // DDRAM start address of each display line
  localparam logic [7:0] LCD_LINE0_BASE = 8'h00;
  localparam logic [7:0] LCD_LINE1_BASE = 8'h40;
  localparam logic [7:0] LCD_LINE2_BASE = 8'h14;
  localparam logic [7:0] LCD_LINE3_BASE = 8'h54;

  // Per-transaction sequencer states
  typedef enum logic [2:0] {
    StPwrup,
    StSetup,
    StEnHi,
    StWait,
    StFetch,
    StIdle
  } lcd_state_e;

  // Which part of the overall job the sequencer is working on
  typedef enum logic [0:0] {
    PhInit,
    PhPaint
  } lcd_phase_e;

  function automatic logic [7:0] line_base(input logic [1:0] line);
    logic [7:0] base;
    base = LCD_LINE0_BASE;
    unique case (line)
      2'd0: base = LCD_LINE0_BASE;
      2'd1: base = LCD_LINE1_BASE;
      2'd2: base = LCD_LINE2_BASE;
      2'd3: base = LCD_LINE3_BASE;
    endcase
    return base;
  endfunction

  // Power-up command list, issued in index order
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] cmd;
    cmd = LCD_FUNC_8B2L;
    unique case (idx)
      2'd0: cmd = LCD_FUNC_8B2L;
      2'd1: cmd = LCD_DISP_ON;
      2'd2: cmd = LCD_ENTRY_INC;
      2'd3: cmd = LCD_CLEAR;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/lcd_tick_gen.sv
// Free-running 1 us strobe: one-cycle pulse every TICK_DIV system clocks.
module lcd_tick_gen #(
  parameter int unsigned TICK_DIV = 125
) (
  input  logic SYS_clk,
  input  logic SYS_reset_n,
  output logic tick
);

  localparam int unsigned TW = $clog2(TICK_DIV);

  logic [TW-1:0] cnt;

  // Divider counter, wraps at TICK_DIV-1
  always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      cnt <= '0;
    end else if (cnt == TW'(TICK_DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + TW'(1);
    end
  end

  assign tick = (cnt == TW'(TICK_DIV - 1));

endmodule

// File: rtl/lcd_text_ctrl.sv
// HD44780-class text controller: power-up init, then paints a LINES x COLS frame fetched
// from an external character store; repaints on request.
module lcd_text_ctrl import lcd_pkg::*; #(
  parameter int unsigned TICK_DIV   = 125,
  parameter int unsigned COLS       = 16,
  parameter int unsigned LINES      = 2,
  parameter int unsigned T_EN_US    = 1,
  parameter int unsigned T_CMD_US   = 50,
  parameter int unsigned T_CLR_US   = 2000,
  parameter int unsigned T_PWRUP_US = 15000,
  localparam int unsigned AW = (LINES * COLS > 1) ? $clog2(LINES * COLS) : 1
) (
  input  logic          SYS_clk,
  input  logic          SYS_reset_n,
  input  logic          refresh,
  output logic [AW-1:0] char_addr,
  input  logic [7:0]    char_data,
  output logic          busy,
  output logic [14:4]   pin
);

  localparam int unsigned DMAX = (T_PWRUP_US > T_CLR_US) ? T_PWRUP_US : T_CLR_US;
  localparam int unsigned DW   = $clog2(DMAX + 1);
  localparam int unsigned CW   = (COLS > 1) ? $clog2(COLS) : 1;

  logic          tick;
  lcd_state_e    state;
  lcd_phase_e    phase;
  logic [DW-1:0] dly;
  logic [1:0]    init_idx;
  logic [1:0]    line;
  logic [CW-1:0] col;
  logic [7:0]    db;
  logic          en;
  logic          rs;
  logic          pending;

  logic          dly_done;
  logic          last_col;
  logic          last_line;
  logic [DW-1:0] wait_load;

  lcd_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .SYS_clk    (SYS_clk),
    .SYS_reset_n(SYS_reset_n),
    .tick       (tick)
  );

  assign dly_done  = (dly == '0);
  assign last_col  = (col == CW'(COLS - 1));
  assign last_line = (line == 2'(LINES - 1));

  // Clear and home need the long post-EN wait; everything else the short one
  always_comb begin
    wait_load = DW'(T_CMD_US - 1);
    if (!rs && (db == LCD_CLEAR || db == LCD_HOME)) begin
      wait_load = DW'(T_CLR_US - 1);
    end
  end

  // Sequencer: phase/item bookkeeping plus the SETUP / EN_HI / WAIT transaction timing
  always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      state     <= StPwrup;
      phase     <= PhInit;
      dly       <= DW'(T_PWRUP_US - 1);
      init_idx  <= '0;
      line      <= '0;
      col       <= '0;
      char_addr <= '0;
      db        <= '0;
      en        <= 1'b0;
      rs        <= 1'b0;
      pending   <= 1'b0;
      busy      <= 1'b1;
    end else begin
      // Requests arriving while painting collapse into one repaint
      if (refresh && busy && phase == PhPaint) begin
        pending <= 1'b1;
      end

      unique case (state)
        StPwrup: begin
          if (tick) begin
            if (dly_done) begin
              phase    <= PhInit;
              init_idx <= '0;
              db       <= init_cmd(2'd0);
              rs       <= 1'b0;
              dly      <= '0;
              state    <= StSetup;
            end else begin
              dly <= dly - DW'(1);
            end
          end
        end

        StSetup: begin
          if (tick) begin
            if (dly_done) begin
              en    <= 1'b1;
              dly   <= DW'(T_EN_US - 1);
              state <= StEnHi;
            end else begin
              dly <= dly - DW'(1);
            end
          end
        end

        StEnHi: begin
          if (tick) begin
            if (dly_done) begin
              en    <= 1'b0;
              dly   <= wait_load;
              state <= StWait;
            end else begin
              dly <= dly - DW'(1);
            end
          end
        end

        StWait: begin
          if (tick) begin
            if (!dly_done) begin
              dly <= dly - DW'(1);
            end else if (phase == PhInit) begin
              rs    <= 1'b0;
              dly   <= '0;
              state <= StSetup;
              if (init_idx == 2'd3) begin
                phase <= PhPaint;
                line  <= '0;
                db    <= LCD_SET_DDRAM | line_base(2'd0);
              end else begin
                init_idx <= init_idx + 2'd1;
                db       <= init_cmd(init_idx + 2'd1);
              end
            end else if (!rs) begin
              // Set-DDRAM just finished: first character of this line
              col       <= '0;
              char_addr <= AW'(line * COLS);
              state     <= StFetch;
            end else if (!last_col) begin
              col       <= col + CW'(1);
              char_addr <= char_addr + AW'(1);
              state     <= StFetch;
            end else if (!last_line) begin
              line  <= line + 2'd1;
              db    <= LCD_SET_DDRAM | line_base(line + 2'd1);
              rs    <= 1'b0;
              dly   <= '0;
              state <= StSetup;
            end else if (pending || refresh) begin
              // A request seen during (or on the last tick of) the paint repaints once more
              pending <= 1'b0;
              line    <= '0;
              db      <= LCD_SET_DDRAM | line_base(2'd0);
              rs      <= 1'b0;
              dly     <= '0;
              state   <= StSetup;
            end else begin
              busy  <= 1'b0;
              state <= StIdle;
            end
          end
        end

        StFetch: begin
          db    <= char_data;
          rs    <= 1'b1;
          dly   <= '0;
          state <= StSetup;
        end

        StIdle: begin
          if (refresh) begin
            busy  <= 1'b1;
            phase <= PhPaint;
            line  <= '0;
            db    <= LCD_SET_DDRAM | line_base(2'd0);
            rs    <= 1'b0;
            dly   <= '0;
            state <= StSetup;
          end
        end

        default: begin
          state <= StPwrup;
        end
      endcase
    end
  end

  assign pin = {db, en, 1'b0, rs};

endmodule
